cart_loader: RTL and testbench
==============================

// Module: cart_loader
// PURPOSE
//  Receives the ROM image byte stream from the ioctl download channel, packs bytes into 16-bit words and
//  writes them to SDRAM through a req/ack handshake. Captures header bytes 0x147/0x148/0x149 and raises
//  cart_ready. Sits directly upstream of the cartridge mapper, which consumes cart_mbc_type,
//  cart_rom_size, cart_ram_size and cart_ready, and reads the ROM back from SDRAM as 16-bit words.
// PARAMETERS
//  ADDR_W       25   byte-address width of ioctl_addr (32MB SDRAM); word address is ADDR_W-1 bits
//  ACK_TIMEOUT  255  max cycles dl_we may wait for dl_ack before dl_err is set
// PORTS
//  clk_sys        in   1         system clock; all logic on posedge
//  reset          in   1         asynchronous, active-high reset
//  ioctl_download in   1         high for the whole ROM transfer
//  ioctl_wr       in   1         1-cycle byte strobe
//  ioctl_addr     in   ADDR_W    byte address of ioctl_dout
//  ioctl_dout     in   8         ROM byte
//  ioctl_wait     out  1         stall; source must hold ioctl_wr low while high
//  dl_we          out  1         SDRAM write request; level, held until dl_ack
//  dl_ack         in   1         1-cycle SDRAM write acknowledge
//  dl_addr        out  ADDR_W-1  SDRAM word address
//  dl_data        out  16        {odd byte, even byte}
//  cart_mbc_type  out  8         header byte 0x147
//  cart_rom_size  out  8         header byte 0x148
//  cart_ram_size  out  8         header byte 0x149
//  cart_ready     out  1         ROM fully written, header valid
//  cart_hdr_ok    out  1         header checksum result (see CONFIGURATION)
//  dl_err         out  1         sticky: overrun or ack timeout
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; timeout counter 0.
//  FSM IDLE->LOAD on ioctl_download rise.
//   - Download rise clears cart_ready, dl_err and all three header regs.
//  LOAD:
//   - ioctl_wr with even addr latches low byte.
//   - ioctl_wr with odd addr loads dl_data={dout,low}, dl_addr=ioctl_addr[ADDR_W-1:1], then ->WRITE.
//  WRITE:
//   - dl_we=1 and ioctl_wait=1 from the cycle after the odd byte.
//   - On dl_ack: dl_we=0 next cycle, then ->LOAD; ioctl_wait drops in the same cycle.
//  Overrun: ioctl_wr while ioctl_wait=1 drops the byte and sets dl_err.
//  Timeout: counter increments each WRITE cycle without ack.
//   - At ACK_TIMEOUT it sets dl_err; the FSM stays in WRITE, and the request is never abandoned.
//  Download fall in LOAD with an unpaired even byte -> FLUSH.
//   - FLUSH writes {8'hFF,low} via the same handshake, then ->DONE.
//  Download fall in LOAD with no unpaired byte -> DONE.
//  Download fall during WRITE: finish the handshake; if a byte is unpaired, FLUSH follows; then DONE.
//  DONE: cart_ready=1 one cycle after entry. Holds until the next download rise (DONE->LOAD directly).
//  Header: bytes at 0x147/0x148/0x149 captured on their ioctl_wr. Addresses >=0x150 never alter them.
//  Re-download: header regs cleared; cart_ready=0 for the whole transfer.
//  Reset mid-transfer: asynchronous return to IDLE, dl_we=0 immediately, partial word discarded.
// CONFIGURATION
//  CART_HDR_CHECK_EN defined:
//   - x starts at 0 at download rise; for each byte at 0x134..0x14C, x = x - byte - 1 (8-bit wrap).
//   - Byte 0x14D is captured.
//   - cart_hdr_ok = (x == byte_14D), valid from the cycle cart_ready rises; it is 0 while not ready.
//  CART_HDR_CHECK_EN undefined: no checksum logic; cart_hdr_ok = cart_ready.
// STRUCTURE
//  Package gb_cart_pkg:
//   - FSM enum {IDLE, LOAD, WRITE, FLUSH, DONE}.
//   - Header offset constants HDR_MBC=16'h147, HDR_ROM=16'h148, HDR_RAM=16'h149.
//   - HDR_CHK_LO=16'h134, HDR_CHK_HI=16'h14C, HDR_CHK_SUM=16'h14D.
//  Sub-module cart_hdr_check:
//   - Holds the checksum accumulator and compare.
//   - Instantiated only under CART_HDR_CHECK_EN.
// TESTING
//  1. 4-byte stream 11,22,33,44 at addr 0..3, dl_ack 2 cycles after dl_we
//     -> writes (0,16'h2211),(1,16'h4433); ioctl_wait high exactly while dl_we pending; cart_ready after fall.
//  2. 0x150-byte image with 0x147=19,0x148=05,0x149=03 -> cart_mbc_type=8'h19, rom_size=5, ram_size=3 at cart_ready.
//  3. Odd-length stream of 3 bytes AA,BB,CC -> second write (1,16'hFFCC) before cart_ready=1.
//  4. ioctl_wr asserted while ioctl_wait=1 -> byte dropped, dl_err=1; dl_ack withheld 300 cycles -> dl_err=1, dl_we still 1.
//  5. CART_HDR_CHECK_EN, valid Tetris-style header with 0x14D correct -> cart_hdr_ok=1; corrupt 0x134 -> 0.
//  6. reset pulsed mid-WRITE -> dl_we=0 same cycle; new download re-clears header regs; cart_ready=0 until end.

Source files
------------

// File: rtl/gb_cart_pkg.sv
// Shared types and header offsets for the cartridge loader.
package gb_cart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        FLUSH,
        DONE
    } cart_state_t;

    localparam logic [15:0] HDR_MBC     = 16'h147;
    localparam logic [15:0] HDR_ROM     = 16'h148;
    localparam logic [15:0] HDR_RAM     = 16'h149;
    localparam logic [15:0] HDR_CHK_LO  = 16'h134;
    localparam logic [15:0] HDR_CHK_HI  = 16'h14C;
    localparam logic [15:0] HDR_CHK_SUM = 16'h14D;

endpackage

// File: rtl/cart_loader_if.sv
// ioctl download channel plus SDRAM word-write request channel.
interface cart_loader_if #(
    parameter int ADDR_W = 25
);
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              ioctl_wait;
    logic              dl_we;
    logic              dl_ack;
    logic [ADDR_W-2:0] dl_addr;
    logic [15:0]       dl_data;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, dl_ack,
        input  ioctl_wait, dl_we, dl_addr, dl_data
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, dl_ack,
        output ioctl_wait, dl_we, dl_addr, dl_data
    );
endinterface

// File: rtl/cart_hdr_check.sv
// Header checksum accumulator over 0x134..0x14C compared against byte 0x14D.
// Only built when CART_HDR_CHECK_EN is defined.
`ifdef CART_HDR_CHECK_EN
module cart_hdr_check
    import gb_cart_pkg::*;
#(
    parameter int ADDR_W = 25
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_we,
    input  logic [ADDR_W-1:0] byte_addr,
    input  logic [7:0]        byte_data,
    input  logic              cart_ready,
    output logic              cart_hdr_ok
);
    logic [7:0] chk_acc;
    logic [7:0] chk_ref;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            chk_acc <= 8'h00;
            chk_ref <= 8'h00;
        end else if (clear) begin
            chk_acc <= 8'h00;
            chk_ref <= 8'h00;
        end else if (byte_we) begin
            if (byte_addr >= ADDR_W'(HDR_CHK_LO) && byte_addr <= ADDR_W'(HDR_CHK_HI))
                chk_acc <= chk_acc - byte_data - 8'd1;
            if (byte_addr == ADDR_W'(HDR_CHK_SUM))
                chk_ref <= byte_data;
        end
    end

    assign cart_hdr_ok = cart_ready && (chk_acc == chk_ref);
endmodule
`endif

// File: rtl/cart_loader.sv
// Packs ioctl ROM bytes into 16-bit SDRAM writes and captures the cartridge header.
// Define CART_HDR_CHECK_EN to compute the header checksum; otherwise cart_hdr_ok follows cart_ready.
module cart_loader
    import gb_cart_pkg::*;
#(
    parameter int ADDR_W      = 25,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic         clk_sys,
    input  logic         reset,
    cart_loader_if.slave bus,
    output logic [7:0]   cart_mbc_type,
    output logic [7:0]   cart_rom_size,
    output logic [7:0]   cart_ram_size,
    output logic         cart_ready,
    output logic         cart_hdr_ok,
    output logic         dl_err
);
    // state | meaning
    // IDLE  | no download seen since reset
    // LOAD  | accepting bytes, pairing even/odd
    // WRITE | word write pending, waiting for dl_ack
    // FLUSH | writing trailing unpaired byte padded with 0xFF
    // DONE  | image complete, cart_ready asserted
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    cart_state_t       state, state_nx;
    logic              download_q;
    logic              dl_rise;
    logic              busy;
    logic              byte_take;
    logic              overrun;
    logic              timeout;
    logic              have_low;
    logic [7:0]        low_byte;
    logic [ADDR_W-2:0] low_word;
    logic [TMO_W-1:0]  tmo_cnt;

    assign dl_rise   = bus.ioctl_download & ~download_q;
    assign byte_take = bus.ioctl_wr && (state == LOAD);
    assign overrun   = bus.ioctl_wr && busy;
    assign timeout   = busy && !bus.dl_ack && (tmo_cnt == TMO_W'(ACK_TIMEOUT));

    assign bus.dl_we      = busy;
    assign bus.ioctl_wait = busy;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        unique case (state)
            IDLE:  if (dl_rise) state_nx = LOAD;
            LOAD: begin
                if (byte_take && bus.ioctl_addr[0])
                    state_nx = WRITE;
                else if (!byte_take && !bus.ioctl_download)
                    state_nx = have_low ? FLUSH : DONE;
            end
            WRITE: begin
                busy = 1'b1;
                if (bus.dl_ack) state_nx = LOAD;
            end
            FLUSH: begin
                busy = 1'b1;
                if (bus.dl_ack) state_nx = DONE;
            end
            DONE:  if (dl_rise) state_nx = LOAD;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            download_q    <= 1'b0;
            have_low      <= 1'b0;
            low_byte      <= 8'h00;
            low_word      <= '0;
            tmo_cnt       <= '0;
            bus.dl_addr   <= '0;
            bus.dl_data   <= 16'h0000;
            cart_mbc_type <= 8'h00;
            cart_rom_size <= 8'h00;
            cart_ram_size <= 8'h00;
            cart_ready    <= 1'b0;
            dl_err        <= 1'b0;
        end else begin
            download_q <= bus.ioctl_download;

            // The request is never abandoned; the counter just saturates so dl_err stays set.
            if (!busy || bus.dl_ack)                   tmo_cnt <= '0;
            else if (tmo_cnt != TMO_W'(ACK_TIMEOUT))   tmo_cnt <= tmo_cnt + 1'b1;

            if (dl_rise) begin
                have_low      <= 1'b0;
                cart_mbc_type <= 8'h00;
                cart_rom_size <= 8'h00;
                cart_ram_size <= 8'h00;
                cart_ready    <= 1'b0;
                dl_err        <= 1'b0;
            end else begin
                if (state == DONE)        cart_ready <= 1'b1;
                if (overrun || timeout)   dl_err     <= 1'b1;

                if (byte_take) begin
                    if (bus.ioctl_addr[0]) begin
                        bus.dl_data <= {bus.ioctl_dout, low_byte};
                        bus.dl_addr <= bus.ioctl_addr[ADDR_W-1:1];
                        have_low    <= 1'b0;
                    end else begin
                        low_byte <= bus.ioctl_dout;
                        low_word <= bus.ioctl_addr[ADDR_W-1:1];
                        have_low <= 1'b1;
                    end
                    if (bus.ioctl_addr == ADDR_W'(HDR_MBC)) cart_mbc_type <= bus.ioctl_dout;
                    if (bus.ioctl_addr == ADDR_W'(HDR_ROM)) cart_rom_size <= bus.ioctl_dout;
                    if (bus.ioctl_addr == ADDR_W'(HDR_RAM)) cart_ram_size <= bus.ioctl_dout;
                end

                if (state == LOAD && state_nx == FLUSH) begin
                    bus.dl_data <= {8'hFF, low_byte};
                    bus.dl_addr <= low_word;
                    have_low    <= 1'b0;
                end
            end
        end
    end

`ifdef CART_HDR_CHECK_EN
    cart_hdr_check #(
        .ADDR_W (ADDR_W)
    ) u_hdr_check (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .clear       (dl_rise),
        .byte_we     (byte_take),
        .byte_addr   (bus.ioctl_addr),
        .byte_data   (bus.ioctl_dout),
        .cart_ready  (cart_ready),
        .cart_hdr_ok (cart_hdr_ok)
    );
`else
    assign cart_hdr_ok = cart_ready;
`endif

endmodule

// File: tb/tb_cart_loader.sv
// Directed bench for cart_loader: expected SDRAM writes are queued as bytes are driven and checked at each handshake.
module tb_cart_loader;
    localparam int ADDR_W = 25;

    typedef struct packed {
        logic [ADDR_W-2:0] addr;
        logic [15:0]       data;
    } wr_t;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic [7:0] cart_mbc_type, cart_rom_size, cart_ram_size;
    logic       cart_ready, cart_hdr_ok, dl_err;

    int n_assert = 0;
    int n_fail   = 0;

    wr_t               exp_q[$];
    logic [7:0]        lo_b;
    logic [ADDR_W-1:0] lo_a;
    logic              lo_v;
    logic [7:0]        hdr_sum;

    cart_loader_if #(.ADDR_W(ADDR_W)) bus ();

    cart_loader #(
        .ADDR_W      (ADDR_W),
        .ACK_TIMEOUT (255)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .bus           (bus),
        .cart_mbc_type (cart_mbc_type),
        .cart_rom_size (cart_rom_size),
        .cart_ram_size (cart_ram_size),
        .cart_ready    (cart_ready),
        .cart_hdr_ok   (cart_hdr_ok),
        .dl_err        (dl_err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_raw(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        tick();
        bus.ioctl_wr   = 1'b0;
    endtask

    // Drive one accepted byte and update the pairing model.
    task automatic wr_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        wr_raw(a, d);
        if (a[0]) begin
            exp_q.push_back('{addr: a[ADDR_W-1:1], data: {d, lo_b}});
            lo_v = 1'b0;
            chk("we_after_odd", {31'd0, bus.dl_we}, 32'd1);
        end else begin
            lo_b = d;
            lo_a = a;
            lo_v = 1'b1;
        end
    endtask

    task automatic service(input int delay);
        wr_t e;
        for (int i = 0; i < 20 && bus.dl_we !== 1'b1; i++) tick();
        chk("we_seen", {31'd0, bus.dl_we}, 32'd1);
        chk("wait_pending", {31'd0, bus.ioctl_wait}, 32'd1);
        n_assert++;
        assert (exp_q.size() > 0) else begin
            n_fail++;
            $error("FAIL sb_empty observed=%0d expected=%0d", 0, 1);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("dl_addr", 32'(bus.dl_addr), 32'(e.addr));
            chk("dl_data", 32'(bus.dl_data), 32'(e.data));
        end
        repeat (delay) tick();
        if (delay > 0) chk("we_held", {31'd0, bus.dl_we & bus.ioctl_wait}, 32'd1);
        bus.dl_ack = 1'b1;
        tick();
        bus.dl_ack = 1'b0;
        chk("we_drop", {31'd0, bus.dl_we}, 32'd0);
        chk("wait_drop", {31'd0, bus.ioctl_wait}, 32'd0);
    endtask

    task automatic put(input logic [ADDR_W-1:0] a, input logic [7:0] d, input int delay);
        wr_byte(a, d);
        if (a[0]) service(delay);
    endtask

    task automatic start_dl();
        bus.ioctl_download = 1'b1;
        tick();
        lo_v = 1'b0;
        chk("rise_ready", {31'd0, cart_ready}, 32'd0);
        chk("rise_err", {31'd0, dl_err}, 32'd0);
        chk("rise_hdr", {8'd0, cart_mbc_type, cart_rom_size, cart_ram_size}, 32'd0);
    endtask

    task automatic end_dl();
        bus.ioctl_download = 1'b0;
        tick();
        if (lo_v) begin
            exp_q.push_back('{addr: lo_a[ADDR_W-1:1], data: {8'hFF, lo_b}});
            lo_v = 1'b0;
            service(1);
        end else begin
            chk("no_flush", {31'd0, bus.dl_we}, 32'd0);
        end
        chk("ready_late", {31'd0, cart_ready}, 32'd0);
        tick();
        chk("ready", {31'd0, cart_ready}, 32'd1);
    endtask

    function automatic logic [7:0] img(input logic [ADDR_W-1:0] a);
        case (a)
            25'h147: img = 8'h19;
            25'h148: img = 8'h05;
            25'h149: img = 8'h03;
            25'h14D: img = hdr_sum;
            default: img = a[7:0] ^ 8'h5A;
        endcase
    endfunction

    task automatic load_image(input logic corrupt);
        logic [7:0] b;
        start_dl();
        for (int a = 0; a < 'h150; a++) begin
            b = img(ADDR_W'(a));
            if (corrupt && a == 'h134) b = b + 8'd1;
            put(ADDR_W'(a), b, 0);
            if (a == 'hA1) chk("ready_mid", {31'd0, cart_ready}, 32'd0);
        end
        put(25'h246, 8'hEE, 0);
        put(25'h247, 8'hEE, 0);
        put(25'h248, 8'hEE, 1);
        put(25'h249, 8'hEE, 0);
        end_dl();
        chk("mbc_type", 32'(cart_mbc_type), 32'h19);
        chk("rom_size", 32'(cart_rom_size), 32'h05);
        chk("ram_size", 32'(cart_ram_size), 32'h03);
    endtask

    initial begin
        logic [7:0] x;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = 8'h00;
        bus.dl_ack         = 1'b0;
        lo_b = 8'h00;
        lo_a = '0;
        lo_v = 1'b0;

        x = 8'h00;
        hdr_sum = 8'h00;
        for (int a = 'h134; a <= 'h14C; a++) x = x - img(ADDR_W'(a)) - 8'd1;
        hdr_sum = x;

        repeat (3) tick();
        chk("rst_we", {31'd0, bus.dl_we}, 32'd0);
        chk("rst_wait", {31'd0, bus.ioctl_wait}, 32'd0);
        chk("rst_flags", {29'd0, cart_ready, cart_hdr_ok, dl_err}, 32'd0);
        chk("rst_hdr", {8'd0, cart_mbc_type, cart_rom_size, cart_ram_size}, 32'd0);
        reset = 1'b0;
        tick();

        // 4-byte stream, ack two cycles after the request
        start_dl();
        put(25'h0, 8'h11, 2);
        put(25'h1, 8'h22, 2);
        put(25'h2, 8'h33, 2);
        put(25'h3, 8'h44, 2);
        end_dl();
        chk("hdr_ok_plain", {31'd0, cart_hdr_ok}, 32'd1);

        // full header image, then a corrupted copy
        load_image(1'b0);
        chk("hdr_ok_good", {31'd0, cart_hdr_ok}, 32'd1);
        load_image(1'b1);
`ifdef CART_HDR_CHECK_EN
        chk("hdr_ok_bad", {31'd0, cart_hdr_ok}, 32'd0);
`else
        chk("hdr_ok_bad", {31'd0, cart_hdr_ok}, 32'd1);
`endif

        // odd-length stream needs a padded flush
        start_dl();
        put(25'h0, 8'hAA, 1);
        put(25'h1, 8'hBB, 1);
        put(25'h2, 8'hCC, 1);
        end_dl();

        // overrun drops the byte and flags dl_err
        start_dl();
        wr_byte(25'h0, 8'h01);
        wr_byte(25'h1, 8'h02);
        wr_raw(25'h2, 8'h55);
        chk("overrun_err", {31'd0, dl_err}, 32'd1);
        service(1);
        end_dl();
        chk("overrun_sticky", {31'd0, dl_err}, 32'd1);

        // ack withheld past the timeout
        start_dl();
        wr_byte(25'h10, 8'h66);
        wr_byte(25'h11, 8'h77);
        repeat (100) tick();
        chk("tmo_early", {31'd0, dl_err}, 32'd0);
        repeat (200) tick();
        chk("tmo_err", {31'd0, dl_err}, 32'd1);
        chk("tmo_we_held", {31'd0, bus.dl_we}, 32'd1);
        service(0);
        end_dl();

        // reset in the middle of a pending write
        start_dl();
        put(25'h146, 8'h00, 0);
        put(25'h147, 8'h19, 0);
        chk("pre_rst_mbc", 32'(cart_mbc_type), 32'h19);
        wr_byte(25'h148, 8'h05);
        wr_byte(25'h149, 8'h03);
        void'(exp_q.pop_back());
        reset = 1'b1;
        #1;
        chk("rst_mid_we", {31'd0, bus.dl_we}, 32'd0);
        chk("rst_mid_wait", {31'd0, bus.ioctl_wait}, 32'd0);
        chk("rst_mid_hdr", {8'd0, cart_mbc_type, cart_rom_size, cart_ram_size}, 32'd0);
        bus.ioctl_download = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        start_dl();
        put(25'h0, 8'h5C, 0);
        put(25'h1, 8'hC5, 0);
        chk("ready_in_xfer", {31'd0, cart_ready}, 32'd0);
        end_dl();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
